// File: rtl/divider_pkg.sv
// Shared defines for the execute stage: ALU opcodes, the double-word bus
// width and the divider state encoding.
package divider_pkg;

   // Double-word bus carrying {HI, LO} results out of the multiply/divide unit.
   localparam int DWORD_W = 64;

   // Width of the divider step counter (enough for 32 steps plus headroom).
   localparam int DIV_CNT_W = 6;

   // ALU opcode constants consumed by the decode/execute stages.
   localparam logic [7:0] ALU_OP_NOP  = 8'b0000_0000;
   localparam logic [7:0] ALU_OP_ADD  = 8'b0010_0000;
   localparam logic [7:0] ALU_OP_SUB  = 8'b0010_0010;
   localparam logic [7:0] ALU_OP_MULT = 8'b0001_1000;
   localparam logic [7:0] ALU_OP_DIV  = 8'b0001_1010;
   localparam logic [7:0] ALU_OP_DIVU = 8'b0001_1011;

   // Divider control states.
   typedef enum logic [1:0] {
      DIV_IDLE = 2'b00,
      DIV_BUSY = 2'b01,
      DIV_DONE = 2'b10
   } div_state_t;

endpackage : divider_pkg

// File: rtl/divider.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// One quotient bit per clock; result on res = {remainder, quotient},
// announced by a one-cycle ready pulse. Divide-by-zero completes after one
// cycle with {dividend, all-ones}.
module divider
   import divider_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               start,
   input  logic               signed_div,
   input  logic [WIDTH-1:0]   opr1,
   input  logic [WIDTH-1:0]   opr2,
   input  logic               cancel,
   output logic               ready,
   output logic               busy,
   output logic [2*WIDTH-1:0] res
);

   localparam logic [DIV_CNT_W-1:0] LAST_STEP = DIV_CNT_W'(WIDTH - 1);

   div_state_t           state;
   logic [DIV_CNT_W-1:0] cnt;
   logic [WIDTH-1:0]     rem_q;     // partial remainder (magnitude)
   logic [WIDTH-1:0]     quo_q;     // dividend shifting out, quotient shifting in
   logic [WIDTH-1:0]     dsr_q;     // divisor magnitude
   logic                 q_neg_q;   // negate quotient at the end
   logic                 r_neg_q;   // negate remainder at the end

   logic                 opr1_neg;
   logic                 opr2_neg;
   logic [WIDTH-1:0]     opr1_mag;
   logic [WIDTH-1:0]     opr2_mag;
   logic [WIDTH:0]       shifted;
   logic [WIDTH:0]       trial;
   logic                 no_borrow;
   logic [WIDTH-1:0]     step_rem;
   logic [WIDTH-1:0]     step_quo;
   logic [WIDTH-1:0]     fin_rem;
   logic [WIDTH-1:0]     fin_quo;

   // Operand magnitudes, one restoring step and the final sign correction.
   always_comb begin
      // NOTE: every signal gets a value on every path through this block, so
      // no latch can be inferred; keep it that way when editing.
      opr1_neg  = signed_div & opr1[WIDTH-1];
      opr2_neg  = signed_div & opr2[WIDTH-1];
      opr1_mag  = opr1_neg ? (~opr1 + 1'b1) : opr1;
      opr2_mag  = opr2_neg ? (~opr2 + 1'b1) : opr2;

      // The partial remainder is always below the divisor, so after the
      // shift it fits in WIDTH+1 bits and one trial subtraction suffices.
      shifted   = {rem_q, quo_q[WIDTH-1]};
      trial     = shifted - {1'b0, dsr_q};
      no_borrow = ~trial[WIDTH];
      step_rem  = no_borrow ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
      step_quo  = {quo_q[WIDTH-2:0], no_borrow};

      fin_quo   = q_neg_q ? (~step_quo + 1'b1) : step_quo;
      fin_rem   = r_neg_q ? (~step_rem + 1'b1) : step_rem;
   end

   // Control FSM and datapath registers; ready, busy and res are registered.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register sees the pre-edge value of every other register.
      if (!resetn) begin
         // NOTE: reset is synchronous and clears the datapath too, so a
         // reset mid-division leaves no stale partial result behind.
         state   <= DIV_IDLE;
         ready   <= 1'b0;
         busy    <= 1'b0;
         res     <= '0;
         cnt     <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dsr_q   <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
      end else begin
         case (state)
            DIV_IDLE: begin
               ready <= 1'b0;
               busy  <= 1'b0;
               // cancel wins over start so a flushed request never launches.
               if (start && !cancel) begin
                  cnt     <= '0;
                  rem_q   <= '0;
                  quo_q   <= opr1_mag;
                  dsr_q   <= opr2_mag;
                  q_neg_q <= opr1_neg ^ opr2_neg;
                  r_neg_q <= opr1_neg;
                  busy    <= 1'b1;
                  if (opr2 == '0) begin
                     // Divide-by-zero: raw dividend in HI, all-ones in LO.
                     state <= DIV_DONE;
                     ready <= 1'b1;
                     res   <= {opr1, {WIDTH{1'b1}}};
                  end else begin
                     state <= DIV_BUSY;
                  end
               end
            end

            DIV_BUSY: begin
               if (cancel) begin
                  state <= DIV_IDLE;
                  busy  <= 1'b0;
                  ready <= 1'b0;
               end else begin
                  rem_q <= step_rem;
                  quo_q <= step_quo;
                  cnt   <= cnt + 1'b1;
                  if (cnt == LAST_STEP) begin
                     state <= DIV_DONE;
                     ready <= 1'b1;
                     res   <= {fin_rem, fin_quo};
                  end
               end
            end

            DIV_DONE: begin
               // Single-cycle result pulse; start here is ignored and
               // cancel leads to the same place.
               state <= DIV_IDLE;
               ready <= 1'b0;
               busy  <= 1'b0;
            end

            default: begin
               state <= DIV_IDLE;
               ready <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule : divider

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 The block SHALL expose these ports, one clock domain, reset synchronous active-low:
- clk  input  1  sole clock, rising edge
- resetn  input  1  synchronous reset, active low
- start  input  1  division request from EX; held high while EX stalls for ready
- signed_div  input  1  1 = signed (DIV), 0 = unsigned (DIVU)
- opr1  input  32  dividend
- opr2  input  32  divisor
- cancel  input  1  pipeline flush/exception abort
- ready  output  1  one-cycle pulse: result valid
- busy  output  1  high when state is not IDLE
- res  output  64  {remainder[63:32] (HI), quotient[31:0] (LO)}
REQ-002 The block SHALL use parameter WIDTH, default 32, operand width; res is 2*WIDTH.

Function
REQ-003 States SHALL be IDLE, BUSY, DONE.
REQ-004 In IDLE, start=1 and cancel=0 at an edge SHALL latch opr1, opr2 and signed_div, clear the 6-bit counter, and enter BUSY. If opr2=0, the block SHALL enter DONE instead.
REQ-005 In the signed mode, operands SHALL be converted to magnitudes on latch. Quotient sign SHALL be opr1[31]^opr2[31]. Remainder sign SHALL be opr1[31].
REQ-006 BUSY SHALL perform one radix-2 restoring step per edge, for 32 edges:
- shift {rem,quo} left by 1
- trial-subtract the divisor magnitude from the 33-bit partial remainder
- set quotient LSB = no borrow
REQ-007 After the 32nd step, the block SHALL enter DONE with res holding sign-corrected quotient and remainder.
REQ-008 In DONE, ready SHALL be 1 for exactly one cycle. The next edge SHALL return to IDLE unconditionally. start seen in DONE SHALL be ignored.
REQ-009 Latency for a nonzero divisor: start high in cycle 0 (sampled at edge E0) → ready high in cycle 33, between E32 and E33.
REQ-010 For divide-by-zero, ready SHALL be high in cycle 1, with res = {opr1, 0xFFFFFFFF}; no sign correction applies.
REQ-011 For signed 0x80000000 / 0xFFFFFFFF, the result SHALL be quotient 0x80000000, remainder 0.
REQ-012 Latched operands SHALL be immutable: opr1, opr2 and signed_div changes after E0 SHALL not affect the result.
REQ-013 cancel=1 at any edge in BUSY or DONE SHALL force IDLE. ready SHALL be 0 in the following cycle. cancel SHALL take priority over start in IDLE.
REQ-014 res SHALL hold its last value until the next completion or reset. res SHALL only be consumed when ready=1.
REQ-015 ready and busy SHALL be registered outputs, with no combinational path from inputs.
REQ-016 start re-asserted in the cycle after ready (IDLE) SHALL begin a new division. Re-issue is idempotent.

Reset
REQ-017 When resetn=0 at an edge, the block SHALL set state=IDLE, ready=0, busy=0, res=0, counter=0, and clear all operand and partial registers. This applies from any state, including mid-BUSY.
REQ-018 Reset SHALL take priority over cancel and start.

Structure
REQ-019 State encodings (DivIdle, DivBusy, DivDone) and the 64-bit DWord bus width SHALL live in the shared Defines file, alongside the ALU opcode constants.
REQ-020 The design SHALL be a single module with no sub-module. Magnitude/negate logic and the 33-bit trial subtractor SHALL be inline.
REQ-021 Nominal size SHALL be 150-250 lines of RTL.

Verification
REQ-022 Unsigned, nonzero divisor: signed_div=0, opr1=100, opr2=7, start held → ready only in cycle 33, res={0x00000002, 0x0000000E}.
REQ-023 Signed, negative dividend: signed_div=1, opr1=0xFFFFFFF9 (-7), opr2=2 → res={0xFFFFFFFF, 0xFFFFFFFD}.
REQ-024 Overflow corner, both modes, opr1=0x80000000, opr2=0xFFFFFFFF:
- signed → res={0x00000000, 0x80000000}
- unsigned → res={0x80000000, 0x00000000}
REQ-025 Divide-by-zero: opr1=5, opr2=0 → ready in cycle 1, res={0x00000005, 0xFFFFFFFF}.
REQ-026 Cancel and restart: cancel=1 in cycle 10 of a 1000/3 division → no ready pulse, busy=0 from cycle 11. A fresh start of 9/3 in cycle 12 → ready in cycle 45, res={0, 3}.
REQ-027 Reset mid-operation: resetn=0 in cycle 20 of a busy division → ready=0, busy=0, res=0 after that edge. Operand changes mid-BUSY (per REQ-012) SHALL not alter the result.
